// File: rtl/matmul_xcel_ws_feeder.sv
// Feeder for the weight-stationary PE array. Weight beats go out unskewed with the
// write enable. Activation beats are skewed diagonally, and the skew is drained after each tile.

module matmul_xcel_ws_feeder_lane #(
  parameter int DEPTH     = 1,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 act_en,
  input  logic [BIT_WIDTH-1:0] act_data,
  input  logic                 wt_en,
  input  logic [BIT_WIDTH-1:0] wt_data,
  output logic [BIT_WIDTH-1:0] q
);
  logic [DEPTH-1:0][BIT_WIDTH-1:0] sr, sr_nxt;

  // A weight bypasses the shift chain and lands directly in the output stage.
  always_comb begin
    sr_nxt = '0;
    for (int i = 1; i < DEPTH; i++) sr_nxt[i] = sr[i-1];
    sr_nxt[0] = act_en ? act_data : '0;
    if (wt_en) sr_nxt[DEPTH-1] = wt_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= sr_nxt;
  end

  assign q = sr[DEPTH-1];
endmodule

module matmul_xcel_ws_feeder #(
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int BIT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_val,
  output logic                                in_rdy,
  input  logic [NUM_ROWS-1:0][BIT_WIDTH-1:0]  in_data,
  input  logic                                in_type,
  input  logic                                in_last,
  output logic [NUM_ROWS-1:0][BIT_WIDTH-1:0]  o_data,
  output logic                                o_wr_weight_ena,
  output logic                                o_act_val,
  output logic                                o_act_last,
  output logic                                o_busy,
  output logic                                o_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;
  localparam int WCW = $clog2(NUM_COLS + 1);
  localparam int DCW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [1:0]     state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [DCW-1:0] dcnt, dcnt_nxt;
  logic           acc_w, acc_a, act_en, wt_en, err_ev;

  assign in_rdy = (state != DRAIN);
  assign o_busy = (state != IDLE);
  assign acc_w  = in_val && in_rdy && in_type;
  assign acc_a  = in_val && in_rdy && !in_type;
  assign act_en = acc_a && (state == IDLE || state == STREAM);
  assign wt_en  = acc_w && (state == IDLE || state == LOAD_W);
  // Wrong beat type for the current phase is dropped and flagged.
  assign err_ev = (acc_a && state == LOAD_W) || (acc_w && state == STREAM);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE, LOAD_W: begin
        if (wt_en) begin
          if (wcnt == WCW'(NUM_COLS - 1)) begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
          end else begin
            state_nxt = LOAD_W;
            wcnt_nxt  = wcnt + WCW'(1);
          end
        end
      end
      DRAIN: begin
        if (dcnt <= DCW'(1)) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt - DCW'(1);
        end
      end
      default: ;
    endcase
    // Activation beats are only enabled in IDLE/STREAM, so this never overlaps a weight issue.
    if (act_en) begin
      if (!in_last) begin
        state_nxt = STREAM;
      end else begin
        state_nxt = (NUM_ROWS == 1) ? IDLE : DRAIN;
        dcnt_nxt  = DCW'(NUM_ROWS - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      wcnt            <= '0;
      dcnt            <= '0;
      o_wr_weight_ena <= 1'b0;
      o_act_val       <= 1'b0;
      o_act_last      <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      dcnt            <= dcnt_nxt;
      o_wr_weight_ena <= wt_en;
      o_act_val       <= act_en;
      o_act_last      <= act_en && in_last;
      o_err           <= o_err | err_ev;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    matmul_xcel_ws_feeder_lane #(.DEPTH(r + 1), .BIT_WIDTH(BIT_WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .act_en   (act_en),
      .act_data (in_data[r]),
      .wt_en    (wt_en),
      .wt_data  (in_data[r]),
      .q        (o_data[r])
    );
  end
endmodule

// File: tb/tb_matmul_xcel_ws_feeder.sv
// Bench for matmul_xcel_ws_feeder: directed vector table, reset sequences, and random
// traffic checked against a beat-scheduling reference model.

module tb_matmul_xcel_ws_feeder;
  localparam int R = 2, C = 2, W = 8, M = 4096;
  typedef logic [R-1:0][W-1:0] vec_t;
  typedef struct {
    logic v, t, l;
    vec_t d, ed;
    logic ewe, eav, eal, erdy, ebusy, eerr;
  } vec_rec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic in_val = 1'b0, in_rdy, in_type = 1'b0, in_last = 1'b0;
  vec_t in_data = '0, o_data;
  logic o_wr_weight_ena, o_act_val, o_act_last, o_busy, o_err;

  matmul_xcel_ws_feeder #(.NUM_ROWS(R), .NUM_COLS(C), .BIT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .in_type(in_type), .in_last(in_last), .o_data(o_data),
    .o_wr_weight_ena(o_wr_weight_ena), .o_act_val(o_act_val), .o_act_last(o_act_last),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // Reference model: a timeline of what each output must show at each cycle,
  // filled in when beats are accepted, plus a few phase variables.
  vec_t m_d [M];
  bit   m_we [M], m_av [M], m_al [M];
  int   wleft, ready_at, err_at;
  bit   in_tile;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < M; i++) begin
      m_d[i] = '0; m_we[i] = 0; m_av[i] = 0; m_al[i] = 0;
    end
    wleft = 0; in_tile = 0; ready_at = 0; err_at = 32'h7fffffff;
  endtask

  task automatic model_accept(input logic t, input logic l, input vec_t d);
    if (t) begin
      if (in_tile) begin
        if (err_at > cyc + 1) err_at = cyc + 1;
      end else begin
        m_d[(cyc + 1) % M] = d;
        m_we[(cyc + 1) % M] = 1;
        wleft = (wleft == 0) ? C - 1 : wleft - 1;
      end
    end else begin
      if (wleft > 0) begin
        if (err_at > cyc + 1) err_at = cyc + 1;
      end else begin
        for (int r = 0; r < R; r++) m_d[(cyc + 1 + r) % M][r] = d[r];
        m_av[(cyc + 1) % M] = 1;
        m_al[(cyc + 1) % M] = l;
        in_tile = !l;
        if (l) ready_at = cyc + R;
      end
    end
  endtask

  // Check this cycle's outputs, drive this cycle's beat, advance one clock.
  task automatic step(input logic v, input logic t, input logic l, input vec_t d,
                      input bit use_tab, input vec_rec_t e);
    vec_t xd;
    logic xwe, xav, xal, xrdy, xbusy, xerr;
    int s;
    s = cyc % M;
    if (use_tab) begin
      xd = e.ed; xwe = e.ewe; xav = e.eav; xal = e.eal;
      xrdy = e.erdy; xbusy = e.ebusy; xerr = e.eerr;
    end else begin
      xd = m_d[s]; xwe = m_we[s]; xav = m_av[s]; xal = m_al[s];
      xrdy = (cyc >= ready_at);
      xbusy = (wleft > 0) || in_tile || (cyc < ready_at);
      xerr = (cyc >= err_at);
    end
    for (int r = 0; r < R; r++) chk($sformatf("o_data[%0d]", r), 32'(o_data[r]), 32'(xd[r]));
    chk("o_wr_weight_ena", 32'(o_wr_weight_ena), 32'(xwe));
    chk("o_act_val", 32'(o_act_val), 32'(xav));
    chk("o_act_last", 32'(o_act_last), 32'(xal));
    chk("in_rdy", 32'(in_rdy), 32'(xrdy));
    chk("o_busy", 32'(o_busy), 32'(xbusy));
    chk("o_err", 32'(o_err), 32'(xerr));
    m_d[s] = '0; m_we[s] = 0; m_av[s] = 0; m_al[s] = 0;
    in_val = v; in_type = t; in_last = l; in_data = d;
    if (v && cyc >= ready_at) model_accept(t, l, d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    for (int r = 0; r < R; r++) chk($sformatf("%s_o_data[%0d]", tag, r), 32'(o_data[r]), 0);
    chk({tag, "_we"}, 32'(o_wr_weight_ena), 0);
    chk({tag, "_act_val"}, 32'(o_act_val), 0);
    chk({tag, "_act_last"}, 32'(o_act_last), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  // Asserted mid-cycle with in_val high; outputs must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    in_val = 1'b1; in_type = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
    in_data = vec_t'($urandom);
    #1;
    chk_zero("rst");
    model_clear();
    @(negedge clk);
    chk_zero("rst_hold");
    reset = 1'b1; in_val = 1'b0;
    #1 chk("rst_rdy", 32'(in_rdy), 1);
  endtask

  function automatic vec_rec_t mk(logic v, logic t, logic l, int d0, int d1, int e0, int e1,
                                  logic we, logic av, logic al, logic rdy, logic busy, logic err);
    vec_rec_t x;
    x.v = v; x.t = t; x.l = l;
    x.d[0] = W'(d0); x.d[1] = W'(d1); x.ed[0] = W'(e0); x.ed[1] = W'(e1);
    x.ewe = we; x.eav = av; x.eal = al; x.erdy = rdy; x.ebusy = busy; x.eerr = err;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t tab [20];
    vec_rec_t dz;
    dz = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //              v t l  d0 d1  e0 e1 we av al rdy busy err
    tab[0]  = mk(1, 1, 0,  1,  2,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[1]  = mk(1, 1, 0,  3,  4,  1, 2, 1, 0, 0, 1, 1, 0);
    tab[2]  = mk(0, 0, 0,  0,  0,  3, 4, 1, 0, 0, 1, 0, 0);
    tab[3]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[4]  = mk(1, 0, 0,  5,  6,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[5]  = mk(1, 0, 1,  7,  8,  5, 0, 0, 1, 0, 1, 1, 0);
    tab[6]  = mk(0, 0, 0,  0,  0,  7, 6, 0, 1, 1, 0, 1, 0);
    tab[7]  = mk(0, 0, 0,  0,  0,  0, 8, 0, 0, 0, 1, 0, 0);
    tab[8]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[9]  = mk(1, 0, 0,  5,  6,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[10] = mk(0, 0, 0,  0,  0,  5, 0, 0, 1, 0, 1, 1, 0);
    tab[11] = mk(1, 0, 1,  7,  8,  0, 6, 0, 0, 0, 1, 1, 0);
    tab[12] = mk(0, 0, 0,  0,  0,  7, 0, 0, 1, 1, 0, 1, 0);
    tab[13] = mk(0, 0, 0,  0,  0,  0, 8, 0, 0, 0, 1, 0, 0);
    tab[14] = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[15] = mk(1, 1, 0,  9, 10,  0, 0, 0, 0, 0, 1, 0, 0);
    tab[16] = mk(1, 0, 0, 11, 12,  9,10, 1, 0, 0, 1, 1, 0);
    tab[17] = mk(1, 1, 0, 13, 14,  0, 0, 0, 0, 0, 1, 1, 1);
    tab[18] = mk(0, 0, 0,  0,  0, 13,14, 1, 0, 0, 1, 0, 1);
    tab[19] = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 1);

    model_clear();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 20; i++) step(tab[i].v, tab[i].t, tab[i].l, tab[i].d, 1, tab[i]);

    // Reset in the middle of a weight load: the next load needs C fresh beats.
    do_reset();
    step(1, 1, 0, vec_t'(16'h1615), 0, dz);
    chk("mid_load_we", 32'(o_wr_weight_ena), 1);
    do_reset();
    step(1, 1, 0, vec_t'(16'h1817), 0, dz);
    chk("fresh_load_busy", 32'(o_busy), 1);
    step(1, 1, 0, vec_t'(16'h1a19), 0, dz);
    chk("fresh_load_done", 32'(o_busy), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, dz);

    for (int b = 0; b < 5; b++) begin
      do_reset();
      for (int k = 0; k < 250; k++)
        step(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 35),
             1'($urandom_range(0, 3) == 0), vec_t'($urandom), 0, dz);
    end
    in_val = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
